// File: rtl/apb_rr_master.sv
// apb_rr_master: shares one APB bus among NUM_REQ local requesters with
// round-robin arbitration. One transfer in flight; SETUP -> ACCESS sequencing;
// back-to-back SETUP when a new request is accepted on the completion edge.
//
// Optional build macro: APB_TIMEOUT_EN
//   Adds a wait-state counter that aborts a transfer after TIMEOUT_CYCLES
//   consecutive ACCESS cycles with PREADY=0 and reports it via rsp_err.
//   Without it the bus waits for PREADY indefinitely and rsp_err is tied 0.
//
// Ports:
//   PCLK, PRESETn                 clock, async active-low reset
//   req_valid/ready/write         per-requester handshake (req_ready is comb)
//   req_addr/wdata/strb           packed per-requester fields, slice i = req i
//   rsp_valid/rsp_rdata/rsp_err   one-hot completion pulse, shared data, error
//   PSELx/PADDR/PWRITE/PSTRB/
//   PWDATA/PENABLE                registered APB master outputs
//   PRDATA/PREADY                 APB slave response
module apb_rr_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned NBYTES         = DATA_WIDTH / 8,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*NBYTES-1:0]      req_strb,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           PSELx,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic                           PWRITE,
    output logic [NBYTES-1:0]              PSTRB,
    output logic [DATA_WIDTH-1:0]          PWDATA,
    output logic                           PENABLE,
    input  logic [DATA_WIDTH-1:0]          PRDATA,
    input  logic                           PREADY
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        last_q, last_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [NBYTES-1:0]       pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    rsp_err_q, rsp_err_d;
`endif

    logic                    gnt_found;
    logic [PTR_W-1:0]        gnt_idx;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [NBYTES-1:0]       sel_strb;
    logic                    sel_write;

    // Round-robin search: indices above last grant first, then wrap to the rest.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[i] && (PTR_W'(i) > last_q)) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[i] && (PTR_W'(i) <= last_q)) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(i);
            end
        end
        accept    = gnt_found &&
                    ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));
        req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    // Field mux for the granted slice.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == gnt_idx) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = req_strb[i*NBYTES +: NBYTES];
                sel_write = req_write[i];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pstrb_d     = pstrb_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif

        case (state_q)
            IDLE: begin
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
`ifdef APB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    if (!accept) begin
                        state_d   = IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the last allowed wait cycle: abort and report.
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept only happens in IDLE or on a completing ACCESS edge.
        if (accept) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = sel_addr;
            pwrite_d  = sel_write;
            pstrb_d   = sel_write ? sel_strb : '0;
            pwdata_d  = sel_write ? sel_wdata : '0;
            owner_d   = gnt_idx;
            last_d    = gnt_idx;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            last_q      <= PTR_W'(NUM_REQ - 1);
            owner_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pstrb_q     <= pstrb_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PSTRB     = pstrb_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed self-checking bench for apb_rr_master (NUM_REQ=4, 32-bit bus).
module tb_apb_rr_master;

    localparam int unsigned NR = 4;

    logic            PCLK;
    logic            PRESETn;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_write;
    logic [NR*32-1:0] req_addr;
    logic [NR*32-1:0] req_wdata;
    logic [NR*4-1:0] req_strb;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            PSELx;
    logic [31:0]     PADDR;
    logic            PWRITE;
    logic [3:0]      PSTRB;
    logic [31:0]     PWDATA;
    logic            PENABLE;
    logic [31:0]     PRDATA;
    logic            PREADY;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    apb_rr_master dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSTRB     (PSTRB),
        .PWDATA    (PWDATA),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[i]        = w;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4]    = s;
    endtask

    task automatic test_reset;
        #12;
        chk_cnt++; if ({PSELx, PENABLE} !== 2'b00) $display("FAIL rst_psel_pen: got %b exp 00", {PSELx, PENABLE}); else pass_cnt++;
        chk_cnt++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PSTRB !== 4'h0 || PWRITE !== 1'b0)
            $display("FAIL rst_apb_fields: got %h %h %h %b exp zeros", PADDR, PWDATA, PSTRB, PWRITE); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 4'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
            $display("FAIL rst_rsp: got %b %h %b exp zeros", rsp_valid, rsp_rdata, rsp_err); else pass_cnt++;
        chk_cnt++; if (req_ready !== 4'b0) $display("FAIL rst_ready: got %b exp 0000", req_ready); else pass_cnt++;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    task automatic test_write_zero_wait;
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        req_valid = 4'b0001;
        #1;
        chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL wr_ready: got %b exp 0001", req_ready); else pass_cnt++;
        tick;  // cycle 1: SETUP
        req_valid = 4'b0000;
        chk_cnt++; if ({PSELx, PENABLE} !== 2'b10) $display("FAIL wr_setup: got %b exp 10", {PSELx, PENABLE}); else pass_cnt++;
        chk_cnt++; if (PADDR !== 32'h10 || PWRITE !== 1'b1 || PSTRB !== 4'hF || PWDATA !== 32'hDEADBEEF)
            $display("FAIL wr_fields: got %h %b %h %h exp 10 1 f deadbeef", PADDR, PWRITE, PSTRB, PWDATA); else pass_cnt++;
        PREADY = 1'b1;
        tick;  // cycle 2: ACCESS
        chk_cnt++; if ({PSELx, PENABLE} !== 2'b11) $display("FAIL wr_access: got %b exp 11", {PSELx, PENABLE}); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 4'b0) $display("FAIL wr_early_rsp: got %b exp 0000", rsp_valid); else pass_cnt++;
        tick;  // cycle 3: response
        PREADY = 1'b0;
        chk_cnt++; if (rsp_valid !== 4'b0001) $display("FAIL wr_rsp_valid: got %b exp 0001", rsp_valid); else pass_cnt++;
        chk_cnt++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) $display("FAIL wr_rsp_data: got %h %b exp 0 0", rsp_rdata, rsp_err); else pass_cnt++;
        chk_cnt++; if ({PSELx, PENABLE} !== 2'b00) $display("FAIL wr_idle: got %b exp 00", {PSELx, PENABLE}); else pass_cnt++;
        tick;
        chk_cnt++; if (rsp_valid !== 4'b0) $display("FAIL wr_pulse_len: got %b exp 0000", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_read_wait2;
        set_req(2, 1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
        req_valid = 4'b0100;
        #1;
        chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL rd_ready: got %b exp 0100", req_ready); else pass_cnt++;
        tick;  // SETUP
        req_valid = 4'b0000;
        chk_cnt++; if (PADDR !== 32'h20 || PWRITE !== 1'b0 || PSTRB !== 4'h0 || PWDATA !== 32'h0)
            $display("FAIL rd_setup_fields: got %h %b %h %h exp 20 0 0 0", PADDR, PWRITE, PSTRB, PWDATA); else pass_cnt++;
        for (int n = 0; n < 2; n++) begin
            tick;  // ACCESS wait states
            chk_cnt++; if ({PSELx, PENABLE} !== 2'b11 || PADDR !== 32'h20 || PWRITE !== 1'b0 || PSTRB !== 4'h0)
                $display("FAIL rd_wait_stable: got %b %h %b %h exp 11 20 0 0", {PSELx, PENABLE}, PADDR, PWRITE, PSTRB); else pass_cnt++;
        end
        tick;  // third ACCESS cycle
        PREADY = 1'b1;
        PRDATA = 32'h12345678;
        chk_cnt++; if ({PSELx, PENABLE} !== 2'b11) $display("FAIL rd_access3: got %b exp 11", {PSELx, PENABLE}); else pass_cnt++;
        tick;
        PREADY = 1'b0;
        PRDATA = 32'h0;
        chk_cnt++; if (rsp_valid !== 4'b0100) $display("FAIL rd_rsp_valid: got %b exp 0100", rsp_valid); else pass_cnt++;
        chk_cnt++; if (rsp_rdata !== 32'h12345678) $display("FAIL rd_rsp_data: got %h exp 12345678", rsp_rdata); else pass_cnt++;
        tick;
        chk_cnt++; if (rsp_valid !== 4'b0 || rsp_rdata !== 32'h12345678)
            $display("FAIL rd_hold: got %b %h exp 0000 12345678", rsp_valid, rsp_rdata); else pass_cnt++;
    endtask

    task automatic test_round_robin;
        int gseq [6] = '{0, 1, 2, 3, 0, 0};
        logic [3:0] exp_v;
        PRESETn = 1'b0;
        tick;
        PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
        PREADY    = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL rr_first: got %b exp 0001", req_ready); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            tick;  // SETUP for gseq[k]
            exp_v = (k == 0) ? 4'b0000 : 4'(1 << gseq[k-1]);
            chk_cnt++; if ({PSELx, PENABLE} !== 2'b10 || PADDR !== 32'h100 + 32'(4 * gseq[k]))
                $display("FAIL rr_setup_%0d: got %b %h exp 10 %h", k, {PSELx, PENABLE}, PADDR, 32'h100 + 32'(4 * gseq[k])); else pass_cnt++;
            chk_cnt++; if (rsp_valid !== exp_v) $display("FAIL rr_rsp_%0d: got %b exp %b", k, rsp_valid, exp_v); else pass_cnt++;
            chk_cnt++; if (req_ready !== 4'b0) $display("FAIL rr_setup_ready_%0d: got %b exp 0000", k, req_ready); else pass_cnt++;
            tick;  // ACCESS
            if (k == 4) begin
                req_valid = 4'b0000;
                #1;
            end
            exp_v = (k == 4) ? 4'b0000 : 4'(1 << gseq[k+1]);
            chk_cnt++; if ({PSELx, PENABLE} !== 2'b11) $display("FAIL rr_access_%0d: got %b exp 11", k, {PSELx, PENABLE}); else pass_cnt++;
            chk_cnt++; if (req_ready !== exp_v) $display("FAIL rr_ready_%0d: got %b exp %b", k, req_ready, exp_v); else pass_cnt++;
        end
        tick;
        chk_cnt++; if (rsp_valid !== 4'b0001 || PSELx !== 1'b0) $display("FAIL rr_last: got %b %b exp 0001 0", rsp_valid, PSELx); else pass_cnt++;
        PREADY = 1'b0;
        tick;
    endtask

    task automatic test_cancel_fairness;
        set_req(3, 1'b0, 32'h30, 32'h0, 4'h0);
        req_valid = 4'b1000;
        #1;
        chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL cf_ready3: got %b exp 1000", req_ready); else pass_cnt++;
        tick;  // SETUP for 3
        req_valid = 4'b0010;
        #1;
        chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL cf_busy_setup: got %b exp 0000", req_ready); else pass_cnt++;
        tick;  // ACCESS wait
        chk_cnt++; if (req_ready !== 4'b0000 || PADDR !== 32'h30) $display("FAIL cf_busy_access: got %b %h exp 0000 30", req_ready, PADDR); else pass_cnt++;
        req_valid = 4'b0000;  // requester 1 cancels
        tick;
        set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h50, 32'h0, 4'h0);
        req_valid = 4'b0101;
        PREADY    = 1'b1;
        PRDATA    = 32'h33;
        #1;
        chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL cf_wrap: got %b exp 0001", req_ready); else pass_cnt++;
        tick;  // SETUP for 0
        req_valid = 4'b0000;
        chk_cnt++; if (rsp_valid !== 4'b1000 || rsp_rdata !== 32'h33) $display("FAIL cf_rsp3: got %b %h exp 1000 33", rsp_valid, rsp_rdata); else pass_cnt++;
        chk_cnt++; if (PADDR !== 32'h40) $display("FAIL cf_addr0: got %h exp 40", PADDR); else pass_cnt++;
        tick;  // ACCESS
        tick;
        chk_cnt++; if (rsp_valid !== 4'b0001 || PSELx !== 1'b0) $display("FAIL cf_rsp0: got %b %b exp 0001 0", rsp_valid, PSELx); else pass_cnt++;
        PREADY = 1'b0;
        PRDATA = 32'h0;
    endtask

    task automatic test_reset_mid_access;
        set_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
        req_valid = 4'b0100;
        tick;  // SETUP
        req_valid = 4'b0000;
        tick;  // ACCESS
        tick;  // ACCESS wait
        #2 PRESETn = 1'b0;
        #1;
        chk_cnt++; if ({PSELx, PENABLE} !== 2'b00 || PADDR !== 32'h0) $display("FAIL rm_bus: got %b %h exp 00 0", {PSELx, PENABLE}, PADDR); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 4'b0 || rsp_rdata !== 32'h0) $display("FAIL rm_rsp: got %b %h exp 0000 0", rsp_valid, rsp_rdata); else pass_cnt++;
        PREADY = 1'b1;
        tick;
        tick;
        PRESETn = 1'b1;
        chk_cnt++; if (rsp_valid !== 4'b0 || PSELx !== 1'b0) $display("FAIL rm_no_rsp: got %b %b exp 0000 0", rsp_valid, PSELx); else pass_cnt++;
        PREADY = 1'b0;
        set_req(0, 1'b0, 32'h60, 32'h0, 4'h0);
        set_req(3, 1'b0, 32'h70, 32'h0, 4'h0);
        req_valid = 4'b1001;
        #1;
        chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL rm_first_grant: got %b exp 0001", req_ready); else pass_cnt++;
        tick;
        req_valid = 4'b0000;
        PREADY    = 1'b1;
        PRDATA    = 32'h55AA55AA;
        chk_cnt++; if (PADDR !== 32'h60) $display("FAIL rm_addr: got %h exp 60", PADDR); else pass_cnt++;
        tick;
        tick;
        chk_cnt++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'h55AA55AA)
            $display("FAIL rm_rsp_after: got %b %h exp 0001 55aa55aa", rsp_valid, rsp_rdata); else pass_cnt++;
        PREADY = 1'b0;
        PRDATA = 32'h0;
    endtask

    task automatic test_timeout;
        set_req(1, 1'b1, 32'h80, 32'h11, 4'hF);
        req_valid = 4'b0010;
        tick;  // SETUP
        req_valid = 4'b0000;
        tick;  // ACCESS cycle 1
`ifdef APB_TIMEOUT_EN
        for (int n = 0; n < 15; n++) begin
            tick;  // ACCESS cycles 2..16
            chk_cnt++; if ({PSELx, PENABLE} !== 2'b11) $display("FAIL to_wait_%0d: got %b exp 11", n, {PSELx, PENABLE}); else pass_cnt++;
        end
        tick;
        chk_cnt++; if ({PSELx, PENABLE} !== 2'b00) $display("FAIL to_abort_bus: got %b exp 00", {PSELx, PENABLE}); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
            $display("FAIL to_abort_rsp: got %b %b %h exp 0010 1 0", rsp_valid, rsp_err, rsp_rdata); else pass_cnt++;
        tick;
        chk_cnt++; if (rsp_valid !== 4'b0 || PSELx !== 1'b0) $display("FAIL to_idle: got %b %b exp 0000 0", rsp_valid, PSELx); else pass_cnt++;
`else
        repeat (110) tick;
        chk_cnt++; if ({PSELx, PENABLE} !== 2'b11) $display("FAIL nto_persist: got %b exp 11", {PSELx, PENABLE}); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 4'b0) $display("FAIL nto_no_rsp: got %b exp 0000", rsp_valid); else pass_cnt++;
        PREADY = 1'b1;
        tick;
        PREADY = 1'b0;
        chk_cnt++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
            $display("FAIL nto_rsp: got %b %b %h exp 0010 0 0", rsp_valid, rsp_err, rsp_rdata); else pass_cnt++;
`endif
    endtask

    initial begin
        PRESETn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        test_reset;
        test_write_zero_wait;
        test_read_wait2;
        test_round_robin;
        test_cancel_fairness;
        test_reset_mid_access;
        test_timeout;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
